// File: rtl/filter_env_gen.sv
// filter_env_gen: ADSR envelope scaled by a signed depth onto a base cutoff, saturated, 3-stage output pipeline.
module filter_env_gen (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_en,
   input  logic               gate,
   input  logic        [15:0] attack_rate,
   input  logic        [15:0] decay_rate,
   input  logic signed [15:0] sustain_level,
   input  logic        [15:0] release_rate,
   input  logic signed [15:0] cutoff_base,
   input  logic signed [15:0] env_depth,
   output logic signed [15:0] cutoff,
   output logic               cutoff_valid,
   output logic signed [15:0] env_out,
   output logic        [2:0]  env_state
);
   typedef enum logic [2:0] {IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4} state_t;
   state_t state_q, state_d;
   logic [14:0] env_q, env_d;
   logic gate_q, v1_q, v2_q, v3_q;
   logic signed [16:0] prod_q;
   logic signed [15:0] cutoff_q, cutoff_d;
   logic rise, fall;
   logic [14:0] sus;
   logic [16:0] atk_sum;
   logic signed [16:0] dec_diff, rel_diff;
   logic signed [31:0] mult;
   logic signed [17:0] sum;
   assign rise = gate & ~gate_q;
   assign fall = ~gate & gate_q;
   assign sus = sustain_level[15] ? 15'd0 : sustain_level[14:0];
   assign atk_sum = {2'b0, env_q} + {1'b0, attack_rate};
   assign dec_diff = $signed({2'b0, env_q}) - $signed({1'b0, decay_rate});
   assign rel_diff = $signed({2'b0, env_q}) - $signed({1'b0, release_rate});
   assign mult = $signed({1'b0, env_q}) * env_depth;
   assign sum = $signed({prod_q[16], prod_q}) + $signed({{2{cutoff_base[15]}}, cutoff_base});
   assign cutoff_d = (sum > 18'sd32767) ? 16'sh7fff : (sum < -18'sd32768) ? 16'sh8000 : sum[15:0];
   // Gate edges take priority over the per-state envelope step; env is held on an edge.
   always_comb begin
      state_d = state_q;
      env_d = env_q;
      if (rise) state_d = ATTACK;
      else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) state_d = RELEASE;
      else begin
         case (state_q)
            IDLE: env_d = '0;
            ATTACK: begin
               state_d = (atk_sum >= 17'd32767) ? DECAY : ATTACK;
               env_d = (atk_sum >= 17'd32767) ? 15'h7fff : atk_sum[14:0];
            end
            DECAY: begin
               state_d = (dec_diff <= $signed({2'b0, sus})) ? SUSTAIN : DECAY;
               env_d = (dec_diff <= $signed({2'b0, sus})) ? sus : dec_diff[14:0];
            end
            SUSTAIN: env_d = sus;
            RELEASE: begin
               state_d = (rel_diff <= 17'sd0) ? IDLE : RELEASE;
               env_d = (rel_diff <= 17'sd0) ? 15'd0 : rel_diff[14:0];
            end
            default: begin
               state_d = IDLE;
               env_d = '0;
            end
         endcase
      end
   end
   // Envelope state advances only on sample strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         env_q <= '0;
         gate_q <= 1'b0;
      end else if (sample_en) begin
         state_q <= state_d;
         env_q <= env_d;
         gate_q <= gate;
      end
   end
   // Output pipeline: scale, then offset and saturate; valids flush on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         prod_q <= '0;
         cutoff_q <= '0;
      end else begin
         v1_q <= sample_en;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (v1_q) prod_q <= 17'(mult >>> 15);
         if (v2_q) cutoff_q <= cutoff_d;
      end
   end
   assign env_out = {1'b0, env_q};
   assign env_state = state_q;
   assign cutoff = cutoff_q;
   assign cutoff_valid = v3_q;
endmodule

// File: tb/tb_filter_env_gen.sv
// tb_filter_env_gen: directed plan plus randomized traffic against a sample-level ADSR reference model.
module tb_filter_env_gen;
   logic clk = 1'b0;
   logic reset = 1'b0, sample_en = 1'b0, gate = 1'b0;
   logic [15:0] attack_rate = '0, decay_rate = '0, release_rate = '0;
   logic signed [15:0] sustain_level = '0, cutoff_base = '0, env_depth = '0;
   logic signed [15:0] cutoff, env_out;
   logic cutoff_valid;
   logic [2:0] env_state;
   int n_chk = 0, n_fail = 0, cyc = 0;
   int m_state = 0, m_env = 0, m_gq = 0, exp_cut = 0;
   typedef struct {int due; int val;} exp_t;
   exp_t pend[$];

   filter_env_gen dut (
      .clk(clk), .reset(reset), .sample_en(sample_en), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_level(sustain_level),
      .release_rate(release_rate), .cutoff_base(cutoff_base), .env_depth(env_depth),
      .cutoff(cutoff), .cutoff_valid(cutoff_valid), .env_out(env_out), .env_state(env_state)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int cut_of(input int e);
      int p, s;
      p = (e * int'(env_depth)) >>> 15;
      s = p + int'(cutoff_base);
      return s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
   endfunction

   task automatic model_sample();
      int sus, t;
      bit rise, fall;
      sus = sustain_level < 0 ? 0 : int'(sustain_level);
      rise = gate && m_gq == 0;
      fall = !gate && m_gq == 1;
      m_gq = gate ? 1 : 0;
      if (rise) m_state = 1;
      else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
      else if (m_state == 0) m_env = 0;
      else if (m_state == 1) begin
         t = m_env + int'(attack_rate);
         if (t >= 32767) begin m_env = 32767; m_state = 2; end else m_env = t;
      end else if (m_state == 2) begin
         t = m_env - int'(decay_rate);
         if (t <= sus) begin m_env = sus; m_state = 3; end else m_env = t;
      end else if (m_state == 3) m_env = sus;
      else begin
         t = m_env - int'(release_rate);
         if (t <= 0) begin m_env = 0; m_state = 0; end else m_env = t;
      end
   endtask

   task automatic do_cycle(input bit se, input bit rs);
      int ev;
      sample_en = se;
      reset = rs;
      if (rs) begin
         m_state = 0; m_env = 0; m_gq = 0; exp_cut = 0;
         pend.delete();
      end else if (se) begin
         model_sample();
         pend.push_back('{due: cyc + 3, val: cut_of(m_env)});
      end
      @(posedge clk);
      #1;
      cyc++;
      ev = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         ev = 1;
         exp_cut = pend[0].val;
         void'(pend.pop_front());
      end
      chk("env", int'(env_out), m_env);
      chk("state", int'(env_state), m_state);
      chk("valid", int'(cutoff_valid), ev);
      chk("cutoff", int'(cutoff), exp_cut);
   endtask

   task automatic smp(input int e_exp, input int s_exp);
      do_cycle(1, 0);
      chk("plan_env", int'(env_out), e_exp);
      chk("plan_state", int'(env_state), s_exp);
      repeat (3) do_cycle(0, 0);
   endtask

   initial begin
      sample_en = 1'b0;
      do_cycle(0, 1);
      do_cycle(1, 1);
      chk("rst_env", int'(env_out), 0);
      chk("rst_state", int'(env_state), 0);
      chk("rst_valid", int'(cutoff_valid), 0);
      chk("rst_cut", int'(cutoff), 0);
      do_cycle(0, 0);
      sustain_level = 16384; attack_rate = 8192; env_depth = 16384; cutoff_base = 100; gate = 1;
      smp(0, 1);
      smp(8192, 1);
      smp(16384, 1);
      smp(24576, 1);
      smp(32767, 2);
      decay_rate = 10000;
      smp(22767, 2);
      smp(16384, 3);
      sustain_level = 8000;
      smp(8000, 3);
      sustain_level = 16384;
      smp(16384, 3);
      gate = 0; release_rate = 20000;
      smp(16384, 4);
      smp(0, 0);
      gate = 1; attack_rate = 12000;
      smp(0, 1);
      smp(12000, 1);
      gate = 0; release_rate = 0;
      smp(12000, 4);
      smp(12000, 4);
      gate = 1; attack_rate = 8192;
      smp(12000, 1);
      smp(20192, 1);
      smp(28384, 1);
      smp(32767, 2);
      decay_rate = 0; env_depth = 32767; cutoff_base = 32000;
      do_cycle(1, 0);
      chk("pos_v1", int'(cutoff_valid), 0);
      do_cycle(0, 0);
      chk("pos_v2", int'(cutoff_valid), 0);
      do_cycle(0, 0);
      chk("pos_v3", int'(cutoff_valid), 1);
      chk("pos_cut", int'(cutoff), 32767);
      do_cycle(0, 0);
      chk("pos_v4", int'(cutoff_valid), 0);
      env_depth = -32768; cutoff_base = -32000;
      do_cycle(1, 0);
      do_cycle(0, 0);
      chk("neg_v2", int'(cutoff_valid), 0);
      do_cycle(0, 0);
      chk("neg_v3", int'(cutoff_valid), 1);
      chk("neg_cut", int'(cutoff), -32768);
      do_cycle(0, 0);
      do_cycle(1, 0);
      do_cycle(1, 0);
      do_cycle(1, 1);
      chk("mid_env", int'(env_out), 0);
      chk("mid_state", int'(env_state), 0);
      chk("mid_cut", int'(cutoff), 0);
      chk("mid_valid", int'(cutoff_valid), 0);
      do_cycle(1, 0);
      chk("mid_v_next", int'(cutoff_valid), 0);
      do_cycle(1, 0);
      chk("mid_v_last", int'(cutoff_valid), 0);
      chk("post_rise", int'(env_state), 1);
      repeat (4) do_cycle(0, 0);
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) begin
            repeat (4) do_cycle(0, 0);
            env_depth = 16'($urandom);
            cutoff_base = 16'($urandom);
         end
         if ($urandom_range(0, 39) == 0) gate = ~gate;
         if ($urandom_range(0, 15) == 0) attack_rate = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4000));
         if ($urandom_range(0, 15) == 0) decay_rate = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4000));
         if ($urandom_range(0, 15) == 0) release_rate = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4000));
         if ($urandom_range(0, 31) == 0) sustain_level = 16'($urandom);
         do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 599) == 0);
      end
      repeat (4) do_cycle(0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/filter_env_gen.md
# filter_env_gen

ADSR envelope generator that drives the `cutoff` input of the resonant low-pass filter stage, directly upstream of it. Once per audio sample it advances a 15-bit envelope through attack/decay/sustain/release under a note gate. It then scales the envelope by a signed depth and adds it to a base cutoff, saturating the result. The result is a signed 16-bit cutoff word with a one-cycle valid strobe.

## Interface
- No parameters; all data paths fixed at 16 bits.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sample_en`  in  1  one-cycle strobe per audio sample; envelope advances only on these cycles.
- `gate`  in  1  note-on level; sampled only on `sample_en` cycles.
- `attack_rate`  in  16  unsigned; envelope increment per sample in ATTACK.
- `decay_rate`  in  16  unsigned; decrement per sample in DECAY.
- `sustain_level`  in  16  signed; sustain target. Negative values are treated as 0.
- `release_rate`  in  16  unsigned; decrement per sample in RELEASE.
- `cutoff_base`  in  16  signed; cutoff when the envelope is 0.
- `env_depth`  in  16  signed Q1.15; envelope modulation depth.
- `cutoff`  out  16  signed; registered, saturated cutoff word.
- `cutoff_valid`  out  1  high for exactly one cycle when `cutoff` updates.
- `env_out`  out  16  signed; current envelope, range 0..32767.
- `env_state`  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- Gate edge detection uses `gate_q`, the gate value captured on the previous `sample_en` cycle.
  - Rise: `gate`=1 and `gate_q`=0.
  - Fall: `gate`=0 and `gate_q`=1.
- Priority on each `sample_en` cycle:
  1. **Rise**: go to ATTACK from any state. `env` is not reset (legato retrigger) and is unchanged this sample.
  2. **Fall** while in ATTACK, DECAY or SUSTAIN: go to RELEASE. `env` is unchanged this sample.
  3. **Otherwise**, apply the per-state step:
     - IDLE: `env`=0.
     - ATTACK: `env`+`attack_rate` is computed in 17 bits. If the sum is ≥32767, set `env`=32767 and go to DECAY.
     - DECAY: `env`−`decay_rate` is computed signed in 17 bits. If the result is ≤ sustain (clamped ≥0), set `env`=sustain and go to SUSTAIN.
     - SUSTAIN: `env` tracks the clamped `sustain_level` every sample.
     - RELEASE: `env`−`release_rate`. If the result is ≤0, set `env`=0 and go to IDLE.
- A rate of 0 holds `env` in ATTACK, DECAY or RELEASE indefinitely.
- Output path, fully pipelined:
  - `prod` = `env`×`env_depth`, a 32-bit signed product, arithmetic shift right by 15.
  - `sum` = `prod`+`cutoff_base`, computed in 18 bits.
  - `cutoff` = `sum` saturated to [−32768, 32767].
- Cycles without `sample_en` leave `env`, state and `gate_q` unchanged. The pipeline keeps draining.

## Timing
- `sample_en` high in cycle N:
  - `env_out`/`env_state` update at N+1.
  - `prod` register updates at N+2.
  - `cutoff` updates and `cutoff_valid`=1 during N+3 only.
- `sample_en` may be high every cycle. The pipeline then produces one `cutoff_valid` per cycle, in order.
- Reset (synchronous, cycle R), effective from R+1:
  - Outputs: `env_out`=0, `env_state`=IDLE, `cutoff`=0, `cutoff_valid`=0.
  - Internal: `gate_q`=0 and all pipeline valids cleared.
  - In-flight samples are discarded with no `cutoff_valid` pulse.
  - `sample_en` during reset is ignored.
  - If `gate` is still 1 on the first `sample_en` after reset, that counts as a rise and enters ATTACK.

## Test plan
- **Attack.** Setup: reset, `sustain_level`=16384, `attack_rate`=8192, `gate`=1, `sample_en` every 4 cycles.
  - Sample 1 enters ATTACK with `env`=0.
  - Then `env` = 8192, 16384, 24576, 32767 (saturated). State is DECAY after the saturating sample.
- **Decay/sustain.** `decay_rate`=10000 from 32767.
  - `env` = 22767, then 16384 (clamped) with state SUSTAIN.
  - Changing `sustain_level` to 8000 gives `env`=8000 on the next sample.
- **Release.** `gate`→0 in SUSTAIN with `env`=16384, `release_rate`=20000.
  - First sample: RELEASE, `env`=16384.
  - Next sample: `env`=0, state IDLE.
- **Retrigger.** Rise in RELEASE at `env`=12000 with `attack_rate`=8192.
  - First sample: ATTACK, `env`=12000.
  - Next sample: `env`=20192.
- **Scaling/saturation.**
  - `env`=32767, `env_depth`=32767, `cutoff_base`=32000 → `prod`=32766, `cutoff`=32767.
  - `env_depth`=−32768, `cutoff_base`=−32000 → `prod`=−32767, `cutoff`=−32768.
  - `cutoff_valid` is exactly at N+3 in both cases.
- **Reset mid-flight.** `sample_en` every cycle for 5 cycles, then `reset` in cycle 3.
  - No `cutoff_valid` for samples issued in cycles ≤3.
  - All outputs are 0 or IDLE at cycle 4.
